axi_rd_batch_sequencer: RTL and testbench

//  Sequences the AXI vec+mat read/preprocess datapath batch by batch for one job.

---
 rtl/axi_rd_batch_sequencer.sv | 161 ++++++++++++++++
 tb/tb_axi_rd_batch_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_batch_sequencer.sv
// axi_rd_batch_sequencer
//   Runs one job of N batches through the AXI vec+mat read/preprocess datapath.
//   Fires initstart, waits for each batch to land, hands it to compute
//   (valid/ack), fires start for the next batch, then waits for alldone.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   IDLE      | no job; accepts i_seq_start
//   INIT      | initstart pulse, first batch transfer begins
//   BLANK     | one dead cycle while the datapath clears its stale done
//   WAIT_DONE | waiting for the batch to land (watchdog running)
//   HANDOFF   | batch valid to compute, waiting for ack (no timeout)
//   NEXT      | start pulse, batch index advances
//   FINISH    | waiting for the datapath to return to idle (watchdog running)
//
// Ports
//   clk, rst_n              clock, async active-low reset
//   i_seq_start             job start pulse (dropped while busy)
//   i_seq_num_batches       batch count N, sampled on accepted start
//   o_seq_busy              job in progress
//   o_seq_done              1-cycle pulse at job end (normal, N==0 or timeout)
//   o_seq_err               sticky watchdog error, cleared on next accepted start
//   o_axird_initstart       1-cycle pulse: begin vec+mat transfer
//   o_axird_start           1-cycle pulse: advance to next batch
//   o_data_size_batches     registered N driven to the datapath
//   i_axird_done            datapath phase done
//   i_axird_alldone         datapath back in idle
//   o_batch_valid           current batch resident for compute
//   o_batch_idx             index of current batch
//   i_batch_ack             compute finished with current batch
module axi_rd_batch_sequencer #(
  parameter int          BATCH_W   = 15,
  parameter int          TMO_W     = 20,
  parameter int unsigned TMO_LIMIT = 20'hFFFFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_seq_start,
  input  logic [BATCH_W-1:0] i_seq_num_batches,
  output logic               o_seq_busy,
  output logic               o_seq_done,
  output logic               o_seq_err,
  output logic               o_axird_initstart,
  output logic               o_axird_start,
  output logic [BATCH_W-1:0] o_data_size_batches,
  input  logic               i_axird_done,
  input  logic               i_axird_alldone,
  output logic               o_batch_valid,
  output logic [BATCH_W-1:0] o_batch_idx,
  input  logic               i_batch_ack
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INIT      = 3'd1,
    S_BLANK     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_HANDOFF   = 3'd4,
    S_NEXT      = 3'd5,
    S_FINISH    = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [BATCH_W-1:0] n_q, n_d;
  logic [BATCH_W-1:0] idx_q, idx_d;
  logic [TMO_W-1:0]   wdog_q, wdog_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               tmo_hit;
  logic               last_batch;

  // Counter reads k in the k-th cycle (from 0) of a watched state, so the
  // limit is hit after exactly TMO_LIMIT cycles there.
  assign tmo_hit    = (wdog_q == TMO_W'(TMO_LIMIT - 1));
  assign last_batch = (idx_q == n_q - BATCH_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      wdog_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      wdog_q  <= wdog_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_seq_start) begin
          n_d   = i_seq_num_batches;
          idx_d = '0;
          err_d = 1'b0;
          // Empty job completes without touching the datapath.
          if (i_seq_num_batches == '0) done_d  = 1'b1;
          else                         state_d = S_INIT;
        end
      end
      S_INIT:  state_d = S_BLANK;
      S_NEXT: begin
        idx_d   = idx_q + BATCH_W'(1);
        state_d = S_BLANK;
      end
      // done still reflects the previous phase for one cycle after a pulse.
      S_BLANK: state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (i_axird_done) begin
          state_d = S_HANDOFF;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          done_d  = 1'b1;
        end
      end
      S_HANDOFF: begin
        if (i_batch_ack) state_d = last_batch ? S_FINISH : S_NEXT;
      end
      S_FINISH: begin
        if (i_axird_alldone) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Clears on entry to a watched state, counts while staying there.
    wdog_d = '0;
    if ((state_q == S_WAIT_DONE || state_q == S_FINISH) && state_d == state_q)
      wdog_d = wdog_q + TMO_W'(1);
  end

  always_comb begin
    o_axird_initstart   = (state_q == S_INIT);
    o_axird_start       = (state_q == S_NEXT);
    o_batch_valid       = (state_q == S_HANDOFF);
    o_seq_busy          = (state_q != S_IDLE);
    o_seq_done          = done_q;
    o_seq_err           = err_q;
    o_data_size_batches = n_q;
    o_batch_idx         = idx_q;
  end

endmodule

// File: tb/tb_axi_rd_batch_sequencer.sv
module tb_axi_rd_batch_sequencer;
  localparam int BATCH_W   = 15;
  localparam int TMO_W     = 20;
  localparam int TMO_LIMIT = 16;
  localparam int MAXC      = 160;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               i_seq_start;
  logic [BATCH_W-1:0] i_seq_num_batches;
  logic               o_seq_busy, o_seq_done, o_seq_err;
  logic               o_axird_initstart, o_axird_start;
  logic [BATCH_W-1:0] o_data_size_batches;
  logic               i_axird_done, i_axird_alldone;
  logic               o_batch_valid;
  logic [BATCH_W-1:0] o_batch_idx;
  logic               i_batch_ack;

  always #5 clk = ~clk;

  axi_rd_batch_sequencer #(
    .BATCH_W(BATCH_W), .TMO_W(TMO_W), .TMO_LIMIT(TMO_LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_seq_start(i_seq_start), .i_seq_num_batches(i_seq_num_batches),
    .o_seq_busy(o_seq_busy), .o_seq_done(o_seq_done), .o_seq_err(o_seq_err),
    .o_axird_initstart(o_axird_initstart), .o_axird_start(o_axird_start),
    .o_data_size_batches(o_data_size_batches),
    .i_axird_done(i_axird_done), .i_axird_alldone(i_axird_alldone),
    .o_batch_valid(o_batch_valid), .o_batch_idx(o_batch_idx),
    .i_batch_ack(i_batch_ack)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_exp = 0;     // batch count the DUT should currently be holding
  bit err_exp = 1'b0; // sticky error the DUT should currently be showing

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, want);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  o_seq_busy, 0);
    chk({tag, "_done"},  o_seq_done, 0);
    chk({tag, "_err"},   o_seq_err, 0);
    chk({tag, "_init"},  o_axird_initstart, 0);
    chk({tag, "_start"}, o_axird_start, 0);
    chk({tag, "_size"},  o_data_size_batches, 0);
    chk({tag, "_valid"}, o_batch_valid, 0);
    chk({tag, "_idx"},   o_batch_idx, 0);
  endtask

  // One job, cycle 0 = cycle in which i_seq_start is driven high.
  // Environment: done reads 1 except cycles p+2..p+d-1 after each pulse at p
  // (so it is stale-high through INIT/BLANK); compute acks a cycles after valid;
  // alldone returns l cycles after the last ack. The expected output timeline
  // is derived from those latencies. d/a/l < 0 picks random values.
  // abort_t >= 0 applies an async reset in that cycle and ends the job.
  task automatic run_job(input int n, input int dfix, input int afix,
                         input int lfix, input int abort_t);
    bit e_init[MAXC], e_start[MAXC], e_valid[MAXC], e_busy[MAXC], e_done[MAXC];
    int e_idx[MAXC];
    bit d_in[MAXC], a_in[MAXC], ad_in[MAXC];
    int p, v, ak, d, a, l, f, len;
    for (int t = 0; t < MAXC; t++) begin
      e_init[t] = 0; e_start[t] = 0; e_valid[t] = 0; e_busy[t] = 0; e_done[t] = 0;
      e_idx[t] = 0; d_in[t] = 1; a_in[t] = 0; ad_in[t] = 1;
    end
    f = 0;
    ak = 0;
    if (n == 0) begin
      e_done[1] = 1;
    end else begin
      p = 1;
      e_init[1] = 1;
      for (int b = 0; b < n; b++) begin
        d = (dfix >= 0) ? dfix : int'($urandom_range(2, 6));
        a = (afix >= 0) ? afix : int'($urandom_range(0, 3));
        if (b > 0) e_start[p] = 1;
        for (int t = p + 2; t < p + d; t++) d_in[t] = 0;
        v  = p + d + 1;
        ak = v + a;
        for (int t = v; t <= ak; t++) begin
          e_valid[t] = 1;
          e_idx[t]   = b;
        end
        a_in[ak] = 1;
        // an ack while the batch is not yet valid must be ignored
        if ($urandom_range(0, 1) == 1) a_in[v-1] = 1;
        p = ak + 1;
      end
      l = (lfix >= 0) ? lfix : int'($urandom_range(1, 5));
      for (int t = 1; t < ak + l; t++) ad_in[t] = 0;
      f = ak + l;
      for (int t = 1; t <= f; t++) e_busy[t] = 1;
      e_done[f+1] = 1;
    end
    len = f + 3;

    for (int t = 0; t < len; t++) begin
      cyc = t;
      // a second start mid-job must not disturb N or idx
      i_seq_start       = (t == 0) || (t == 3 && n > 0);
      i_seq_num_batches = (t == 0) ? BATCH_W'(n) : BATCH_W'(n + 1 + int'($urandom_range(0, 4)));
      i_axird_done      = d_in[t];
      i_axird_alldone   = ad_in[t];
      i_batch_ack       = a_in[t];
      @(negedge clk);
      chk("initstart", o_axird_initstart, e_init[t]);
      chk("start",     o_axird_start,     e_start[t]);
      chk("valid",     o_batch_valid,     e_valid[t]);
      chk("busy",      o_seq_busy,        e_busy[t]);
      chk("seq_done",  o_seq_done,        e_done[t]);
      chk("seq_err",   o_seq_err,         (t == 0) ? err_exp : 1'b0);
      chk("size",      o_data_size_batches, (t == 0) ? n_exp : n);
      if (e_valid[t]) chk("idx", o_batch_idx, e_idx[t]);
      if (t == abort_t) begin
        #1 rst_n = 1'b0;
        #1 chk_all_zero("rst_mid");
        i_seq_start = 0; i_batch_ack = 0; i_axird_done = 1; i_axird_alldone = 1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_exp   = 0;
        err_exp = 0;
        return;
      end
      @(posedge clk); #1;
    end
    i_seq_start = 0;
    n_exp   = n;
    err_exp = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    i_seq_start = 0; i_seq_num_batches = '0; i_batch_ack = 0;
    i_axird_done = 1; i_axird_alldone = 1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_job(3, 5, 2, 3, -1);  // three batches, fixed latencies
    run_job(1, 4, 1, 4, -1);  // single batch, no start pulse, alldone 4 after ack
    run_job(2, 5, 1, 2, -1);  // stale done through INIT/BLANK, low 3 cycles
    run_job(0, -1, -1, -1, -1); // empty job

    // watchdog: done never returns after initstart
    for (int t = 0; t < 22; t++) begin
      cyc = t;
      i_seq_start       = (t == 0);
      i_seq_num_batches = BATCH_W'(2);
      i_axird_done      = (t < 3);
      i_axird_alldone   = (t == 0);
      i_batch_ack       = 0;
      @(negedge clk);
      chk("tmo_init",  o_axird_initstart, t == 1);
      chk("tmo_start", o_axird_start, 0);
      chk("tmo_valid", o_batch_valid, 0);
      chk("tmo_busy",  o_seq_busy, (t >= 1 && t <= 2 + TMO_LIMIT));
      chk("tmo_done",  o_seq_done, t == 3 + TMO_LIMIT);
      chk("tmo_err",   o_seq_err, t >= 3 + TMO_LIMIT);
      @(posedge clk); #1;
    end
    i_seq_start = 0; i_axird_done = 1; i_axird_alldone = 1;
    n_exp   = 2;
    err_exp = 1;
    run_job(2, 3, 1, 2, -1);  // clears sticky error

    run_job(3, 2, 5, 2, 14);  // reset while HANDOFF idx=1
    run_job(2, -1, -1, -1, -1);

    for (int j = 0; j < 12; j++)
      run_job(int'($urandom_range(0, 4)), -1, -1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
